// File: rtl/bit_select_pkg.sv
// Shared types for the bit-select serializer: operating mode and FSM states.
package bit_select_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // ST_PARITY is only reachable when BIT_SELECT_PARITY_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/bit_index_counter.sv
// Up/down bit-index counter for the serializer: load seeds the index of the
// second frame bit, step walks toward the last bit, last flags the final index.
module bit_index_counter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int SEL_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [SEL_W-1:0] idx,
  output logic             last
);

  // The first bit leaves straight from the parallel word, so load lands one past it.
  localparam logic [SEL_W-1:0] START = MSB_FIRST ? SEL_W'(WIDTH - 2) : SEL_W'(1);
  localparam logic [SEL_W-1:0] FINAL = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       idx <= '0;
    else if (load) idx <= START;
    else if (step) idx <= MSB_FIRST ? idx - 1'b1 : idx + 1'b1;
  end

  assign last = (idx == FINAL);

endmodule

// File: rtl/bit_select_serializer.sv
// Registered bit selector (manual mode) plus start/ready word serializer (scan mode).
// Optional trailing even-parity bit when BIT_SELECT_PARITY_EN is defined.
module bit_select_serializer
  import bit_select_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  input  logic             start,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int FIRST = MSB_FIRST ? WIDTH - 1 : 0;

  state_e           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic             out_n, valid_n, done_n;
  logic             load, step, last;
  logic [SEL_W-1:0] idx;

  bit_index_counter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .SEL_W     (SEL_W)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .idx  (idx),
    .last (last)
  );

  assign ready = (state == ST_IDLE);

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    out_n    = out;
    valid_n  = 1'b0;
    done_n   = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode_e'(mode) == MODE_MANUAL) begin
          // Out-of-range selects (non power-of-two WIDTH) give an invalid 0.
          if (32'(sel) < WIDTH) begin
            out_n   = in[sel];
            valid_n = 1'b1;
          end else begin
            out_n   = 1'b0;
          end
        end else if (start) begin
          shadow_n = in;
          out_n    = in[FIRST];
          valid_n  = 1'b1;
          load     = 1'b1;
          state_n  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        out_n   = shadow[idx];
        valid_n = 1'b1;
        step    = 1'b1;
        if (last) begin
`ifdef BIT_SELECT_PARITY_EN
          state_n = ST_PARITY;
`else
          done_n  = 1'b1;
          state_n = ST_IDLE;
`endif
        end
      end
      ST_PARITY: begin
        out_n   = ^shadow;
        valid_n = 1'b1;
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shadow    <= shadow_n;
      out       <= out_n;
      out_valid <= valid_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_bit_select_serializer.sv
// Directed bench: manual-mode vector table plus hand-written scan frames,
// back-to-back frames and mid-frame reset across WIDTH=8 LSB/MSB and WIDTH=6.
module tb_bit_select_serializer;

`ifdef BIT_SELECT_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in8;
  logic [2:0] sel;
  logic       mode, start;
  logic       rdy_l, out_l, vld_l, done_l;
  logic       rdy_m, out_m, vld_m, done_m;
  logic       rdy_s, out_s, vld_s, done_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bit_select_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in(in8), .sel(sel), .mode(mode), .start(start),
    .ready(rdy_l), .out(out_l), .out_valid(vld_l), .done(done_l));

  bit_select_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in(in8), .sel(sel), .mode(mode), .start(start),
    .ready(rdy_m), .out(out_m), .out_valid(vld_m), .done(done_m));

  bit_select_serializer #(.WIDTH(6), .MSB_FIRST(1'b0)) u_w6 (
    .clk(clk), .rst(rst), .in(in8[5:0]), .sel(sel), .mode(mode), .start(start),
    .ready(rdy_s), .out(out_s), .out_valid(vld_s), .done(done_s));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scan frame on both WIDTH=8 instances; in8 switches to mid_in partway.
  task automatic frame(input logic [7:0] d, input bit keep_start, input logic [7:0] mid_in);
    logic el, em;
    in8   = d;
    mode  = 1'b1;
    start = 1'b1;
    for (int k = 0; k < FL; k++) begin
      tick();
      if (k == 0 && !keep_start) start = 1'b0;
      if (k == 3) in8 = mid_in;
      el = (k < 8) ? d[k]     : ^d;
      em = (k < 8) ? d[7 - k] : ^d;
      chk($sformatf("lsb_out[%0h:%0d]", d, k), out_l, el);
      chk($sformatf("msb_out[%0h:%0d]", d, k), out_m, em);
      chk($sformatf("lsb_vld[%0h:%0d]", d, k), vld_l, 1);
      chk($sformatf("msb_vld[%0h:%0d]", d, k), vld_m, 1);
      chk($sformatf("lsb_done[%0h:%0d]", d, k), done_l, (k == FL - 1) ? 1 : 0);
      chk($sformatf("msb_done[%0h:%0d]", d, k), done_m, (k == FL - 1) ? 1 : 0);
      chk($sformatf("lsb_ready[%0h:%0d]", d, k), rdy_l, (k == FL - 1) ? 1 : 0);
    end
  endtask

  typedef struct {
    logic [7:0] in;
    logic [2:0] sel;
    logic       exp8;
    logic       exp6;
    logic       vld6;
  } man_vec_t;

  man_vec_t mv[10];

  initial begin
    // in=1000_0100: bits 2 and 7 set; WIDTH=6 sees 00_0100 and rejects sel 6,7.
    for (int i = 0; i < 8; i++) begin
      mv[i].in   = 8'b1000_0100;
      mv[i].sel  = 3'(i);
      mv[i].exp8 = (i == 2 || i == 7);
      mv[i].exp6 = (i == 2);
      mv[i].vld6 = (i < 6);
    end
    mv[8] = '{in: 8'h3C, sel: 3'd5, exp8: 1'b1, exp6: 1'b1, vld6: 1'b1};
    mv[9] = '{in: 8'hFF, sel: 3'd7, exp8: 1'b1, exp6: 1'b0, vld6: 1'b0};

    rst = 1'b1; in8 = '0; sel = '0; mode = 1'b0; start = 1'b0;
    #12;
    chk("rst_out",   out_l, 0);
    chk("rst_vld",   vld_l, 0);
    chk("rst_done",  done_l, 0);
    chk("rst_ready", rdy_l, 1);
    rst = 1'b0;

    // Manual mode: start is held high to confirm it is ignored.
    start = 1'b1;
    foreach (mv[i]) begin
      in8 = mv[i].in;
      sel = mv[i].sel;
      tick();
      chk($sformatf("man8_out[%0d]", i),  out_l, mv[i].exp8);
      chk($sformatf("man8_vld[%0d]", i),  vld_l, 1);
      chk($sformatf("manm_out[%0d]", i),  out_m, mv[i].exp8);
      chk($sformatf("man6_out[%0d]", i),  out_s, mv[i].exp6);
      chk($sformatf("man6_vld[%0d]", i),  vld_s, mv[i].vld6);
      chk($sformatf("man_done[%0d]", i),  done_l, 0);
      chk($sformatf("man_ready[%0d]", i), rdy_l, 1);
    end
    start = 1'b0;

    // Single scan frames; in changes mid-frame must not disturb the stream.
    frame(8'hA5, 1'b0, 8'hA5);
    tick();
    chk("idle_vld",  vld_l, 0);
    chk("idle_done", done_l, 0);
    chk("idle_hold", out_l, (FL == 9) ? ^8'hA5 : 1);
    frame(8'h81, 1'b0, 8'h00);
    tick();
    chk("idle_vld2", vld_m, 0);
    frame(8'h07, 1'b0, 8'h07);
    tick();
    frame(8'h03, 1'b0, 8'hFF);
    tick();

    // Back-to-back: start stays high, second frame follows with no valid gap.
    frame(8'hFF, 1'b1, 8'hFF);
    frame(8'h00, 1'b1, 8'h00);
    start = 1'b0;
    tick();
    chk("b2b_end_vld", vld_l, 0);

    // Mid-frame asynchronous reset abandons the frame.
    frame_start_and_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic frame_start_and_reset();
    in8 = 8'hA5; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_out",   out_l, 1);
    chk("pre_rst_ready", rdy_l, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out",   out_l, 0);
    chk("mid_rst_vld",   vld_l, 0);
    chk("mid_rst_done",  done_l, 0);
    chk("mid_rst_ready", rdy_l, 1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post_rst_done[%0d]", k), done_l | done_m, 0);
      chk($sformatf("post_rst_vld[%0d]", k),  vld_l, 0);
    end
    chk("post_rst_ready", rdy_l, 1);
  endtask

endmodule
